// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
//   DW_DEF/AW_DEF/CNTW_DEF : default data, address and contention-counter widths
//   SRC0/SRC1              : source indices (pipeline WB, multi-cycle unit)
//   rr_state_e             : round-robin pointer state
package regfile_write_arbiter_pkg;

  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned AW_DEF   = 5;
  localparam int unsigned CNTW_DEF = 16;

  localparam int unsigned SRC0 = 0;
  localparam int unsigned SRC1 = 1;

  typedef enum logic {
    RR_SRC0 = 1'b0,
    RR_SRC1 = 1'b1
  } rr_state_e;

endpackage

// File: rtl/regfile_write_arbiter_wb_hold_buffer.sv
// One-entry writeback holding buffer with valid/ready handshake.
//   clk, resetb          : clock, synchronous active-low reset
//   valid, addr, data    : incoming writeback
//   ready                : combinational; free slot or slot draining this cycle
//   drain                : arbiter grant, empties the slot at the next edge
//   full, held_addr/data : buffered entry
module wb_hold_buffer
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          valid,
  output logic          ready,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  input  logic          drain,
  output logic          full,
  output logic [AW-1:0] held_addr,
  output logic [DW-1:0] held_data
);

  logic accept;

  // A draining slot can take a new entry in the same cycle.
  assign ready  = resetb & (~full | drain);
  assign accept = valid & ready;

  // Slot register; a new accept wins over a same-cycle drain.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      full      <= 1'b0;
      held_addr <= '0;
      held_data <= '0;
    end else if (accept) begin
      full      <= 1'b1;
      held_addr <= addr;
      held_data <= data;
    end else if (drain) begin
      full      <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the pipeline WB (src0) and the
// multi-cycle unit (src1) through two holding buffers, a round-robin arbiter
// and a registered write stage.
//   Clk, Resetb            : clock, synchronous active-low reset
//   Src{0,1}Valid/Addr/Data: writeback requests; Src{0,1}Ready combinational
//   RW, BusW, RegWr        : register-file write port
//   Busy                   : any buffer full or write stage valid
//   Contention             : saturating count of both-buffers-full cycles
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned CNTW = CNTW_DEF
) (
  input  logic            Clk,
  input  logic            Resetb,
  input  logic            Src0Valid,
  output logic            Src0Ready,
  input  logic [AW-1:0]   Src0Addr,
  input  logic [DW-1:0]   Src0Data,
  input  logic            Src1Valid,
  output logic            Src1Ready,
  input  logic [AW-1:0]   Src1Addr,
  input  logic [DW-1:0]   Src1Data,
  output logic [AW-1:0]   RW,
  output logic [DW-1:0]   BusW,
  output logic            RegWr,
  output logic            Busy,
  output logic [CNTW-1:0] Contention
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [1:0]    full;
  logic [1:0]    grant;
  logic [AW-1:0] buf0_addr, buf1_addr, win_addr;
  logic [DW-1:0] buf0_data, buf1_data, win_data;
  logic          both_full, same_addr;
  rr_state_e     rr_q, rr_d;

  wb_hold_buffer #(.AW(AW), .DW(DW)) u_buf0 (
    .clk       (Clk),
    .resetb    (Resetb),
    .valid     (Src0Valid),
    .ready     (Src0Ready),
    .addr      (Src0Addr),
    .data      (Src0Data),
    .drain     (grant[SRC0]),
    .full      (full[SRC0]),
    .held_addr (buf0_addr),
    .held_data (buf0_data)
  );

  wb_hold_buffer #(.AW(AW), .DW(DW)) u_buf1 (
    .clk       (Clk),
    .resetb    (Resetb),
    .valid     (Src1Valid),
    .ready     (Src1Ready),
    .addr      (Src1Addr),
    .data      (Src1Data),
    .drain     (grant[SRC1]),
    .full      (full[SRC1]),
    .held_addr (buf1_addr),
    .held_data (buf1_data)
  );

  assign both_full = full[SRC0] & full[SRC1];
  assign same_addr = both_full & (buf0_addr == buf1_addr);

  // Round-robin pointer register.
  always_ff @(posedge Clk) begin
    if (!Resetb) rr_q <= RR_SRC0;
    else         rr_q <= rr_d;
  end

  // Grant and next pointer. Same-address conflicts always drain src1 first so
  // the younger src0 result is the one left in the register.
  always_comb begin
    grant = '0;
    rr_d  = rr_q;
    if (both_full) begin
      if (same_addr || rr_q == RR_SRC1) begin
        grant[SRC1] = 1'b1;
        rr_d        = RR_SRC0;
      end else begin
        grant[SRC0] = 1'b1;
        rr_d        = RR_SRC1;
      end
    end else if (full[SRC0]) begin
      grant[SRC0] = 1'b1;
    end else if (full[SRC1]) begin
      grant[SRC1] = 1'b1;
    end
  end

  assign win_addr = grant[SRC1] ? buf1_addr : buf0_addr;
  assign win_data = grant[SRC1] ? buf1_data : buf0_data;

  // Write stage and contention counter; R0 entries move RW/BusW but never write.
  always_ff @(posedge Clk) begin
    if (!Resetb) begin
      RW         <= '0;
      BusW       <= '0;
      RegWr      <= 1'b0;
      Contention <= '0;
    end else begin
      if (|grant) begin
        RW    <= win_addr;
        BusW  <= win_data;
        RegWr <= (win_addr != '0);
      end else begin
        RegWr <= 1'b0;
      end
      if (both_full && Contention != CNT_MAX) begin
        Contention <= Contention + CNTW'(1);
      end
    end
  end

  assign Busy = (|full) | RegWr;

endmodule
